wr_full_gen: RTL and testbench
==============================

WR_FULL_GEN -- requirements
Module: wr_full_gen

Interface
REQ-001 The block SHALL have parameter PTR_W, default 4, giving pointer width including the wrap bit (FIFO depth 2^(PTR_W-1) = 8).
REQ-002 The block SHALL have parameter AF_LEVEL, default 6, giving the fill level at or above which f_almost_full asserts.
REQ-003 The block SHALL have port wr_clk, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port wr_ptr, input, PTR_W bits: Gray-coded write pointer with wrap bit, registered in wr_clk by the write control block.
REQ-006 The block SHALL have port rd_ptr, input, PTR_W bits: Gray-coded read pointer from the read clock domain, asynchronous to wr_clk.
REQ-007 The block SHALL have port f_full, output, 1 bit: FIFO full, consumed by the write control block.
REQ-008 The block SHALL have port f_almost_full, output, 1 bit: fill level >= AF_LEVEL.
REQ-009 The block SHALL have port wr_level, output, PTR_W bits: entries currently held, 0..8, as seen from the write domain.

Function
REQ-010 rd_ptr SHALL pass through a two-flop synchronizer (rd_sync1 -> rd_sync2) clocked by wr_clk; no other logic SHALL read rd_sync1.
REQ-011 f_full SHALL be combinational from wr_ptr and rd_sync2: 1 when wr_ptr == {~rd_sync2[PTR_W-1:PTR_W-2], rd_sync2[PTR_W-3:0]}, else 0.
REQ-012 Latency: a change on rd_ptr SHALL affect f_full after exactly 2 wr_clk rising edges; a change on wr_ptr SHALL affect f_full in the same cycle.
REQ-013 rd_sync2 and wr_ptr SHALL each be Gray-to-binary converted (b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]).
REQ-014 wr_level SHALL be registered: (wr_bin - rd_bin) modulo 2^PTR_W, updated every wr_clk edge, one cycle after its inputs.
REQ-015 Wrap-around: pointer wrap from 1000 (Gray, binary 15) to 0000 SHALL produce the correct modulo difference, with no transient level above 8.
REQ-016 Empty, wr_ptr == rd_sync2: f_full = 0, wr_level = 0 on the next edge.
REQ-017 Simultaneous read and write advance in one cycle SHALL leave f_full unchanged except where REQ-011 dictates; wr_level SHALL reflect both moves (net 0 after sync latency).
REQ-018 f_full SHALL stay 1 until the synchronized read pointer advances, even though the read domain has already freed an entry (pessimistic full).
REQ-019 The block SHALL NOT modify wr_ptr or rd_ptr and holds no FIFO storage.

Reset
REQ-020 On reset_n = 0, rd_sync1, rd_sync2, wr_level and the f_almost_full register SHALL clear to 0 immediately, without waiting for wr_clk.
REQ-021 With wr_ptr = 0 during reset, f_full SHALL read 0.
REQ-022 Reset mid-operation SHALL discard the synchronizer contents; after release, rd_ptr SHALL reappear on rd_sync2 after 2 edges.

Configuration
REQ-023 Macro WR_ALMOST_FULL_EN defined: f_almost_full SHALL be a register set on each edge to (next wr_level >= AF_LEVEL), asserting in the same cycle wr_level reaches AF_LEVEL.
REQ-024 Macro WR_ALMOST_FULL_EN undefined: f_almost_full SHALL be tied to constant 0, with no comparator or register; all other behaviour is unchanged.

Verification
REQ-025 The bench SHALL cover reset: reset_n = 0 with arbitrary rd_ptr -> f_full = 0, wr_level = 0, f_almost_full = 0, asynchronously.
REQ-026 The bench SHALL cover fill to full: rd_ptr = 0000, wr_ptr stepped 0000 -> 1100 (binary 8) -> wr_level = 8 and f_full = 1 when wr_ptr = 1100; f_full = 0 at wr_ptr = 0100 (level 7).
REQ-027 The bench SHALL cover sync latency: with full at wr_ptr = 1100, set rd_ptr = 0001 -> f_full stays 1 for 2 edges, then 0; wr_level = 7 one edge later.
REQ-028 The bench SHALL cover wrap: wr_ptr = 0000 after wrap (binary 0), rd_ptr = 1100 synced (binary 8) -> f_full = 1, wr_level = 8.
REQ-029 The bench SHALL cover almost full: with WR_ALMOST_FULL_EN defined, AF_LEVEL = 6, rd_ptr = 0000, wr_ptr = 0101 (binary 6) -> f_almost_full = 1; at 0111 (binary 5) -> 0; without the macro -> always 0.
REQ-030 The bench SHALL cover mid-operation reset: reset_n pulsed low while full -> f_full drops on the pointer reset, sync registers read 0, and normal operation resumes 2 edges after release.

Source files
------------

// File: rtl/wr_full_gen.sv
// wr_full_gen: write-domain full / level generator for an asynchronous FIFO.
//   - Brings the Gray read pointer into wr_clk through a two-flop synchronizer.
//   - f_full is combinational from wr_ptr and the synchronized read pointer.
//   - wr_level is the registered modulo difference of the binary pointers.
// Optional feature: define WR_ALMOST_FULL_EN to build the registered
// f_almost_full flag; otherwise f_almost_full is tied to 0.
module wr_full_gen #(
  parameter int PTR_W    = 4,
  parameter int AF_LEVEL = 6
) (
  input  logic             wr_clk,
  input  logic             reset_n,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic             f_full,
  output logic             f_almost_full,
  output logic [PTR_W-1:0] wr_level
);

  // Full compare inverts the two top Gray bits, so at least three bits are needed,
  // and the almost-full threshold must be a reachable level.
  if (PTR_W < 3) begin : g_ptr_w_too_small
    $error("wr_full_gen: PTR_W must be at least 3");
  end
  if (AF_LEVEL > (1 << (PTR_W - 1))) begin : g_af_level_unreachable
    $error("wr_full_gen: AF_LEVEL exceeds FIFO depth");
  end

  logic [PTR_W-1:0] rd_sync1_q;
  logic [PTR_W-1:0] rd_sync2_q;
  logic [PTR_W-1:0] wr_level_q;
  logic [PTR_W-1:0] wr_level_d;
  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] rd_bin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wr_bin = gray2bin(wr_ptr);
  assign rd_bin = gray2bin(rd_sync2_q);

  // Subtraction in PTR_W bits wraps naturally, so pointer wrap needs no special case.
  assign wr_level_d = wr_bin - rd_bin;

  // Full when the write pointer is exactly one lap ahead of the synchronized read
  // pointer: in Gray code that means the two top bits differ and the rest match.
  assign f_full = (wr_ptr == {~rd_sync2_q[PTR_W-1:PTR_W-2], rd_sync2_q[PTR_W-3:0]});

  // Read-pointer synchronizer and registered fill level.
  // NOTE: state uses non-blocking assignments so rd_sync2_q samples the old
  // rd_sync1_q; blocking here would collapse the two flops into one.
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync1_q <= '0;
      rd_sync2_q <= '0;
      wr_level_q <= '0;
    end else begin
      rd_sync1_q <= rd_ptr;
      rd_sync2_q <= rd_sync1_q;
      wr_level_q <= wr_level_d;
    end
  end

  assign wr_level = wr_level_q;

`ifdef WR_ALMOST_FULL_EN
  localparam logic [PTR_W-1:0] AF_LEVEL_L = PTR_W'(AF_LEVEL);

  logic af_q;

  // Almost-full looks at the next level so it asserts together with wr_level.
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (wr_level_d >= AF_LEVEL_L);
    end
  end

  assign f_almost_full = af_q;
`else
  assign f_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wr_full_gen.sv
// Self-checking bench for wr_full_gen: directed vector table, hand-written
// reset sequences, then randomized pointers checked against a reference model.
module tb_wr_full_gen;

  localparam int PTR_W    = 4;
  localparam int AF_LEVEL = 6;
  localparam int MODN     = 16;
  localparam int DEPTH    = 8;
`ifdef WR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic             wr_clk = 1'b0;
  logic             reset_n;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             f_full;
  logic             f_almost_full;
  logic [PTR_W-1:0] wr_level;

  wr_full_gen #(.PTR_W(PTR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .wr_clk       (wr_clk),
    .reset_n      (reset_n),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .f_full       (f_full),
    .f_almost_full(f_almost_full),
    .wr_level     (wr_level)
  );

  always #5 wr_clk = ~wr_clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [3:0] wr;
    logic [3:0] rd;
    int         edges;
    int         exp_full;
    int         exp_level;
  } vec_t;

  vec_t tbl[$];

  // Reference model: read pointer values seen at each edge, oldest first; the
  // write domain acts on the value captured two edges ago.
  int rd_q[$];
  int m_level;

  function automatic logic [3:0] g(input int b);
    int v;
    v = b ^ (b >> 1);
    return v[3:0];
  endfunction

  function automatic int bin_of(input logic [3:0] gv);
    for (int b = 0; b < MODN; b++) begin
      if (g(b) == gv) return b;
    end
    return -1;
  endfunction

  function automatic int mod_n(input int x);
    return ((x % MODN) + MODN) % MODN;
  endfunction

  function automatic int exp_full_m();
    return (mod_n(bin_of(wr_ptr) - rd_q[0]) == DEPTH) ? 1 : 0;
  endfunction

  function automatic int exp_af_of(input int lvl);
    return (AF_EN && lvl >= AF_LEVEL) ? 1 : 0;
  endfunction

  task automatic model_clear();
    rd_q.delete();
    rd_q.push_back(0);
    rd_q.push_back(0);
    m_level = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int full, input int lvl);
    check({name, " f_full"}, int'(f_full), full);
    check({name, " wr_level"}, int'(wr_level), lvl);
    check({name, " f_almost_full"}, int'(f_almost_full), exp_af_of(lvl));
  endtask

  task automatic check_model(input string name);
    check_outs(name, exp_full_m(), m_level);
  endtask

  // One rising edge; the model advances on the pre-edge inputs, then we sit 1ns past.
  task automatic tick();
    int wb;
    int rb;
    bit in_rst;
    wb     = bin_of(wr_ptr);
    rb     = bin_of(rd_ptr);
    in_rst = !reset_n;
    @(posedge wr_clk);
    if (in_rst) begin
      model_clear();
    end else begin
      m_level = mod_n(wb - rd_q[0]);
      rd_q.push_back(rb);
      void'(rd_q.pop_front());
    end
    #1;
  endtask

  task automatic add(input string n, input int wb, input int rb, input int e,
                     input int f, input int l);
    vec_t v;
    v.name = n; v.wr = g(wb); v.rd = g(rb); v.edges = e;
    v.exp_full = f; v.exp_level = l;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    wr_ptr  = 4'b0000;
    rd_ptr  = 4'b1011;
    model_clear();
    repeat (2) tick();
    check_outs("reset_state", 0, 0);
    rd_ptr  = 4'b0000;
    reset_n = 1'b1;

    // Directed table: binary pointer values, expected full and level.
    add("idle", 0, 0, 2, 0, 0);
    for (int b = 1; b < 8; b++) add($sformatf("fill_%0d", b), b, 0, 1, 0, b);
    add("full_same_cycle", 8, 0, 0, 1, 7);
    add("full_level8", 8, 0, 1, 1, 8);
    add("sync_edge1", 8, 1, 1, 1, 8);
    add("sync_edge2", 8, 1, 1, 0, 8);
    add("sync_level7", 8, 1, 1, 0, 7);
    add("empty", 8, 8, 3, 0, 0);
    for (int k = 1; k <= 8; k++) add($sformatf("wrap_%0d", k), (8 + k) % MODN, 8, 1, (k == 8) ? 1 : 0, k);
    add("rd9_sync", 0, 9, 2, 0, 8);
    add("rd9_level", 0, 9, 1, 0, 7);
    add("simul_sync", 1, 10, 2, 0, 8);
    add("simul_net", 1, 10, 1, 0, 7);

    foreach (tbl[i]) begin
      wr_ptr = tbl[i].wr;
      rd_ptr = tbl[i].rd;
      if (tbl[i].edges == 0) #1;
      else repeat (tbl[i].edges) tick();
      check_outs(tbl[i].name, tbl[i].exp_full, tbl[i].exp_level);
    end

    // Mid-operation reset while full: synchronizer contents must be discarded.
    wr_ptr = g(15);
    rd_ptr = g(7);
    repeat (3) tick();
    check_outs("pre_reset_full", 1, 8);
    #2;
    reset_n = 1'b0;
    wr_ptr  = 4'b0000;
    rd_ptr  = 4'b1100;
    model_clear();
    #1;
    check_outs("async_reset", 0, 0);
    repeat (2) tick();
    check_outs("held_reset", 0, 0);
    reset_n = 1'b1;
    tick();
    check_outs("release_edge1", 0, 0);
    tick();
    check_outs("release_edge2", 1, 0);
    tick();
    check_outs("release_edge3", 1, 8);

    // Randomized pointers with occasional asynchronous reset pulses.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        model_clear();
      end else begin
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) wr_ptr = g(int'($urandom_range(0, MODN - 1)));
      if ($urandom_range(0, 1) == 1) rd_ptr = g(int'($urandom_range(0, MODN - 1)));
      #1;
      check_model($sformatf("rand_comb_%0d", it));
      tick();
      check_model($sformatf("rand_edge_%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
